// File: rtl/serial_width_adapter.sv
// Bidirectional width adapter between the chip's narrow serial link and the
// 32-bit host bridge word interface: gathers beats to words and scatters words to beats.
module serial_width_adapter #(
    parameter int NARROW_W = 4,
    parameter int WIDE_W   = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                chip_out_valid,
    output logic                chip_out_ready,
    input  logic [NARROW_W-1:0] chip_out_bits,
    output logic                host_out_valid,
    input  logic                host_out_ready,
    output logic [WIDE_W-1:0]   host_out_bits,
    input  logic                host_in_valid,
    output logic                host_in_ready,
    input  logic [WIDE_W-1:0]   host_in_bits,
    output logic                chip_in_valid,
    input  logic                chip_in_ready,
    output logic [NARROW_W-1:0] chip_in_bits
);

    localparam int RATIO = WIDE_W / NARROW_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    typedef enum logic {G_FILL, G_FULL} g_state_t;
    typedef enum logic {S_IDLE, S_SEND} s_state_t;

    // Holds both ready outputs low until the first clock after reset releases.
    logic active;

    g_state_t          g_state, g_next;
    logic [CNT_W-1:0]  gcnt, gcnt_next;
    logic [WIDE_W-1:0] gdata;

    s_state_t          s_state, s_next;
    logic [CNT_W-1:0]  scnt, scnt_next;
    logic [WIDE_W-1:0] sdata;

    logic chip_out_fire, host_out_fire, host_in_fire, chip_in_fire;

    always_comb begin
        chip_out_ready = active && (g_state == G_FILL);
        host_out_valid = (g_state == G_FULL);
        host_in_ready  = active && (s_state == S_IDLE);
        chip_in_valid  = (s_state == S_SEND);
        host_out_bits  = gdata;
        chip_in_bits   = sdata[NARROW_W-1:0];
    end

    assign chip_out_fire = chip_out_valid && chip_out_ready;
    assign host_out_fire = host_out_valid && host_out_ready;
    assign host_in_fire  = host_in_valid && host_in_ready;
    assign chip_in_fire  = chip_in_valid && chip_in_ready;

    always_comb begin
        g_next    = g_state;
        gcnt_next = gcnt;
        case (g_state)
            G_FILL: begin
                if (chip_out_fire) begin
                    if (gcnt == LAST) begin
                        gcnt_next = '0;
                        g_next    = G_FULL;
                    end else begin
                        gcnt_next = gcnt + CNT_W'(1);
                    end
                end
            end
            G_FULL: begin
                if (host_out_fire) g_next = G_FILL;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_next    = s_state;
        scnt_next = scnt;
        case (s_state)
            S_IDLE: begin
                if (host_in_fire) begin
                    scnt_next = '0;
                    s_next    = S_SEND;
                end
            end
            S_SEND: begin
                if (chip_in_fire) begin
                    if (scnt == LAST) begin
                        scnt_next = '0;
                        s_next    = S_IDLE;
                    end else begin
                        scnt_next = scnt + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            active  <= 1'b0;
            g_state <= G_FILL;
            gcnt    <= '0;
            gdata   <= '0;
            s_state <= S_IDLE;
            scnt    <= '0;
            sdata   <= '0;
        end else begin
            active  <= 1'b1;
            g_state <= g_next;
            gcnt    <= gcnt_next;
            s_state <= s_next;
            scnt    <= scnt_next;
            if (chip_out_fire) begin
                for (int unsigned k = 0; k < RATIO; k++) begin
                    if (gcnt == CNT_W'(k)) gdata[k*NARROW_W +: NARROW_W] <= chip_out_bits;
                end
            end
            if (host_in_fire) sdata <= host_in_bits;
            else if (chip_in_fire) sdata <= sdata >> NARROW_W;
        end
    end

endmodule

// File: tb/tb_serial_width_adapter.sv
// Directed bench for serial_width_adapter with NARROW_W=4, WIDE_W=32.
module tb_serial_width_adapter;

    logic        clock = 1'b0;
    logic        reset;
    logic        chip_out_valid, chip_out_ready;
    logic [3:0]  chip_out_bits;
    logic        host_out_valid, host_out_ready;
    logic [31:0] host_out_bits;
    logic        host_in_valid, host_in_ready;
    logic [31:0] host_in_bits;
    logic        chip_in_valid, chip_in_ready;
    logic [3:0]  chip_in_bits;

    int passed = 0;
    int total  = 0;
    logic [31:0] gw [100];
    logic [31:0] sw [100];

    serial_width_adapter #(.NARROW_W(4), .WIDE_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .chip_out_valid (chip_out_valid),
        .chip_out_ready (chip_out_ready),
        .chip_out_bits  (chip_out_bits),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .host_out_bits  (host_out_bits),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_in_bits   (host_in_bits),
        .chip_in_valid  (chip_in_valid),
        .chip_in_ready  (chip_in_ready),
        .chip_in_bits   (chip_in_bits)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_chip_out_ready"}, 32'(chip_out_ready), 32'd0);
        check({tag, "_host_out_valid"}, 32'(host_out_valid), 32'd0);
        check({tag, "_host_out_bits"},  host_out_bits,       32'd0);
        check({tag, "_host_in_ready"},  32'(host_in_ready),  32'd0);
        check({tag, "_chip_in_valid"},  32'(chip_in_valid),  32'd0);
        check({tag, "_chip_in_bits"},   32'(chip_in_bits),   32'd0);
    endtask

    // Beats 1..8 on consecutive cycles with the host always ready.
    task automatic gather_seq(input string tag);
        host_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) check({tag, "_ready_first"}, 32'(chip_out_ready), 32'd1);
            if (k == 7) check({tag, "_valid_early"}, 32'(host_out_valid), 32'd0);
            chip_out_valid = 1'b1;
            chip_out_bits  = 4'(k + 1);
            tick();
        end
        chip_out_valid = 1'b0;
        check({tag, "_word_valid"}, 32'(host_out_valid), 32'd1);
        check({tag, "_word_bits"},  host_out_bits,       32'h87654321);
        check({tag, "_busy_ready"}, 32'(chip_out_ready), 32'd0);
        tick();
        check({tag, "_valid_one_cycle"}, 32'(host_out_valid), 32'd0);
        check({tag, "_ready_again"},     32'(chip_out_ready), 32'd1);
    endtask

    task automatic run_traffic(input int n, input bit full_rate);
        int gi = 0, gb = 0, go = 0, si = 0, so = 0, sc = 0, cyc = 0;
        int last_h = -1, last_s = -1;
        bit g_f, h_f, hi_f, c_f, hold_h, hold_c;
        logic [31:0] tmp, held_h;
        logic [3:0]  held_c;
        while ((go < n || so < n) && cyc < 6000) begin
            tmp            = (gi < n) ? gw[gi] >> (4 * gb) : 32'd0;
            chip_out_valid = (gi < n);
            chip_out_bits  = tmp[3:0];
            host_out_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            host_in_valid  = (si < n);
            host_in_bits   = (si < n) ? sw[si] : 32'd0;
            chip_in_ready  = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            g_f  = chip_out_valid && chip_out_ready;
            h_f  = host_out_valid && host_out_ready;
            hi_f = host_in_valid && host_in_ready;
            c_f  = chip_in_valid && chip_in_ready;
            if (h_f) begin
                check("gather_word", host_out_bits, (go < n) ? gw[go] : 32'hXXXXXXXX);
                if (full_rate && last_h >= 0) check("gather_rate", 32'(cyc - last_h), 32'd9);
                last_h = cyc;
            end
            if (hi_f) begin
                if (full_rate && last_s >= 0) check("scatter_rate", 32'(cyc - last_s), 32'd9);
                last_s = cyc;
            end
            if (c_f) begin
                tmp = (so < n) ? sw[so] >> (4 * sc) : 32'hXXXXXXXX;
                check("scatter_beat", 32'(chip_in_bits), 32'(tmp[3:0]));
            end
            hold_h = host_out_valid && !host_out_ready;
            held_h = host_out_bits;
            hold_c = chip_in_valid && !chip_in_ready;
            held_c = chip_in_bits;
            tick();
            cyc++;
            if (g_f) begin
                if (gb == 7) begin gb = 0; gi++; end else gb++;
            end
            if (h_f) go++;
            if (hi_f) si++;
            if (c_f) begin
                if (sc == 7) begin sc = 0; so++; end else sc++;
            end
            if (hold_h) begin
                check("hold_out_valid", 32'(host_out_valid), 32'd1);
                check("hold_out_bits",  host_out_bits,       held_h);
            end
            if (hold_c) begin
                check("hold_in_valid", 32'(chip_in_valid), 32'd1);
                check("hold_in_bits",  32'(chip_in_bits),  32'(held_c));
            end
        end
        chip_out_valid = 1'b0;
        host_in_valid  = 1'b0;
        check("gather_words_done",  32'(go), 32'(n));
        check("scatter_words_done", 32'(so), 32'(n));
    endtask

    initial begin
        for (int i = 0; i < 100; i++) begin
            gw[i] = 32'(i + 1) * 32'h9E3779B9 ^ 32'h01234567;
            sw[i] = 32'(i + 7) * 32'h85EBCA6B ^ 32'hC2B2AE35;
        end
        reset          = 1'b1;
        chip_out_valid = 1'b0;
        chip_out_bits  = '0;
        host_out_ready = 1'b0;
        host_in_valid  = 1'b0;
        host_in_bits   = '0;
        chip_in_ready  = 1'b0;

        // Reset held for three cycles, all outputs zero throughout.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("reset");
        end
        reset = 1'b0;
        tick();
        check("post_reset_chip_out_ready", 32'(chip_out_ready), 32'd1);
        check("post_reset_host_in_ready",  32'(host_in_ready),  32'd1);
        check("post_reset_host_out_valid", 32'(host_out_valid), 32'd0);
        check("post_reset_chip_in_valid",  32'(chip_in_valid),  32'd0);

        gather_seq("gather");

        // Scatter 0xDEADBEEF with the chip always ready.
        chip_in_ready = 1'b1;
        host_in_valid = 1'b1;
        host_in_bits  = 32'hDEADBEEF;
        tick();
        host_in_valid = 1'b0;
        begin
            logic [31:0] w;
            w = 32'hDEADBEEF;
            for (int i = 0; i < 8; i++) begin
                check("scatter_valid", 32'(chip_in_valid), 32'd1);
                check("scatter_beat_dir", 32'(chip_in_bits), 32'(w[3:0]));
                check("scatter_busy_ready", 32'(host_in_ready), 32'd0);
                w = w >> 4;
                tick();
            end
        end
        check("scatter_ready_ninth", 32'(host_in_ready), 32'd1);
        check("scatter_idle_valid",  32'(chip_in_valid), 32'd0);

        run_traffic(100, 1'b0);
        run_traffic(10, 1'b1);

        // Partial gather of 3 beats and partial scatter of 5 beats, then reset.
        host_out_ready = 1'b1;
        chip_in_ready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chip_out_valid = 1'b1;
            chip_out_bits  = 4'(4'hA + k);
            tick();
        end
        chip_out_valid = 1'b0;
        host_in_valid  = 1'b1;
        host_in_bits   = 32'h13579BDF;
        tick();
        host_in_valid = 1'b0;
        chip_in_ready = 1'b1;
        repeat (5) tick();
        chip_in_ready = 1'b0;
        check("midop_send_valid", 32'(chip_in_valid), 32'd1);
        check("midop_send_bits",  32'(chip_in_bits),  32'h5);
        reset = 1'b1;
        tick();
        check_all_zero("midop_reset");
        reset = 1'b0;
        chip_in_ready = 1'b1;
        tick();
        check("midop_no_stale_beat", 32'(chip_in_valid), 32'd0);
        gather_seq("midop_gather");
        check("midop_idle_after", 32'(chip_in_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
